// File: rtl/latch_interval_fifo_if.sv
// Bundle of the latch-side input and register-bank readout signals of
// latch_interval_fifo. The block itself uses the slave modport; the
// register bank, or a testbench standing in for it, uses the master modport.
interface latch_interval_fifo_if #(
  parameter int AW = 4
);
  logic [31:0] count_latched;
  logic        rd_en;
  logic        ovf_clr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [AW:0] level;
  logic        overflow;
  logic [31:0] event_count;

  modport master (
    output count_latched, rd_en, ovf_clr,
    input  rd_data, rd_valid, level, overflow, event_count
  );

  modport slave (
    input  count_latched, rd_en, ovf_clr,
    output rd_data, rd_valid, level, overflow, event_count
  );
endinterface

// File: rtl/latch_interval_fifo.sv
// Watches the latched counter value, turns every change into a latch event,
// and queues the modular interval since the previous event in a show-ahead
// FIFO. It also keeps a sticky overflow flag and a running event count.
// The first event after reset only primes the reference and queues nothing.
module latch_interval_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  latch_interval_fifo_if.slave bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] prev_q,      prev_d;
  logic        primed_q,    primed_d;
  logic [AW:0] wr_ptr_q,    wr_ptr_d;
  logic [AW:0] rd_ptr_q,    rd_ptr_d;
  logic        overflow_q,  overflow_d;
  logic [31:0] event_cnt_q, event_cnt_d;

  // Interval storage: distributed RAM, read through the registered rd_ptr.
  logic [31:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic        evt;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] interval;

  // Pointer-derived status; the extra MSB tells full from empty.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  end

  // Event detection, push/pop/drop arbitration and next-state computation.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    evt         = (bus.count_latched != prev_q);
    // Subtraction modulo 2^32 gives the true interval across counter wrap.
    interval    = bus.count_latched - prev_q;
    pop         = bus.rd_en & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push        = evt & primed_q & (~full | pop);
    drop        = evt & primed_q & full & ~pop;

    prev_d      = prev_q;
    primed_d    = primed_q;
    event_cnt_d = event_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;

    if (evt) begin
      prev_d      = bus.count_latched;
      primed_d    = 1'b1;
      event_cnt_d = event_cnt_q + 32'd1;
    end

    if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};

    // A drop and a clear in the same cycle leave the flag set.
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // Control registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rstn) begin
      prev_q      <= '0;
      primed_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      prev_q      <= prev_d;
      primed_q    <= primed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  // Interval storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset, so it maps onto RAM; stale contents
    // are never visible because rd_data is gated by the pointer-derived empty.
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= interval;
  end

  // ---------------------------------------------------------------------------
  // Outputs: registered or derived from pointers, never from rd_en.
  // ---------------------------------------------------------------------------
  // Show-ahead head, forced to zero while empty so reset clears it at once.
  always_comb begin
    bus.rd_data     = empty ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];
    bus.rd_valid    = ~empty;
    bus.level       = wr_ptr_q - rd_ptr_q;
    bus.overflow    = overflow_q;
    bus.event_count = event_cnt_q;
  end

endmodule

// File: tb/tb_latch_interval_fifo.sv
// Directed bench for latch_interval_fifo. A queue-based model of the interval
// FIFO is checked against the DUT on every falling edge, and literal
// hand-computed values pin the key scenarios.
module tb_latch_interval_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  latch_interval_fifo_if #(.AW(AW)) bus ();

  latch_interval_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_q [$];
  logic [31:0] m_prev;
  bit          m_primed;
  bit          m_ovf;
  logic [31:0] m_evcnt;
  bit          m_drop;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q.delete();
      m_prev   = 32'd0;
      m_primed = 1'b0;
      m_ovf    = 1'b0;
      m_evcnt  = 32'd0;
    end else begin
      m_drop = 1'b0;
      // Pop first: a departing head frees room for a same-cycle push.
      if (bus.rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (bus.count_latched != m_prev) begin
        m_evcnt = m_evcnt + 32'd1;
        if (m_primed) begin
          if (m_q.size() < DEPTH) m_q.push_back(bus.count_latched - m_prev);
          else                    m_drop = 1'b1;
        end
        m_primed = 1'b1;
        m_prev   = bus.count_latched;
      end
      if (m_drop)           m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc.rd_valid",    {31'd0, bus.rd_valid}, {31'd0, m_q.size() != 0});
      check("cyc.level",       {27'd0, bus.level},    32'(m_q.size()));
      check("cyc.rd_data",     bus.rd_data,           (m_q.size() != 0) ? m_q[0] : 32'd0);
      check("cyc.overflow",    {31'd0, bus.overflow}, {31'd0, m_ovf});
      check("cyc.event_count", bus.event_count,       m_evcnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn              = 1'b0;
    bus.count_latched = 32'd0;
    bus.rd_en         = 1'b0;
    bus.ovf_clr       = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  logic [31:0] v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn              = 1'b0;
    bus.count_latched = 32'd0;
    bus.rd_en         = 1'b0;
    bus.ovf_clr       = 1'b0;
    do_reset();
    cmp_en = 1'b1;

    // Reset state.
    check("rst.level",       {27'd0, bus.level},    32'd0);
    check("rst.rd_valid",    {31'd0, bus.rd_valid}, 32'd0);
    check("rst.rd_data",     bus.rd_data,           32'd0);
    check("rst.overflow",    {31'd0, bus.overflow}, 32'd0);
    check("rst.event_count", bus.event_count,       32'd0);

    // Basic sequence 0 -> 100 -> 350 -> 1350.
    bus.count_latched = 32'd100;  tick(20);
    check("seq.prime_level", {27'd0, bus.level}, 32'd0);
    bus.count_latched = 32'd350;  tick(20);
    bus.count_latched = 32'd1350; tick(20);
    check("seq.level",       {27'd0, bus.level}, 32'd2);
    check("seq.head",        bus.rd_data,        32'd250);
    check("seq.event_count", bus.event_count,    32'd3);
    bus.rd_en = 1'b1; tick(1); bus.rd_en = 1'b0;
    check("seq.head2", bus.rd_data, 32'd1000);
    bus.rd_en = 1'b1; tick(1); bus.rd_en = 1'b0;
    check("seq.empty", {31'd0, bus.rd_valid}, 32'd0);

    // Wrap-around interval, with one-cycle push latency.
    do_reset();
    bus.count_latched = 32'hFFFF_FF00; tick(3);
    bus.count_latched = 32'h0000_0010; tick(1);
    check("wrap.level", {27'd0, bus.level}, 32'd1);
    check("wrap.head",  bus.rd_data,        32'h110);
    bus.rd_en = 1'b1; tick(1); bus.rd_en = 1'b0;

    // Fill past full: intervals 11..27, the 17th (27) is dropped.
    do_reset();
    v = 32'd1000;
    bus.count_latched = v; tick(1);
    for (int k = 0; k < 17; k++) begin
      v = v + 32'(11 + k);
      bus.count_latched = v;
      tick(1);
    end
    tick(1);
    check("full.level",    {27'd0, bus.level},    32'd16);
    check("full.overflow", {31'd0, bus.overflow}, 32'd1);
    check("full.head",     bus.rd_data,           32'd11);
    bus.ovf_clr = 1'b1; tick(1); bus.ovf_clr = 1'b0;
    check("ovf.cleared", {31'd0, bus.overflow}, 32'd0);
    // Drop in the same cycle as the clear: set wins.
    v = v + 32'd5;
    bus.count_latched = v; bus.ovf_clr = 1'b1; tick(1); bus.ovf_clr = 1'b0;
    check("ovf.set_wins", {31'd0, bus.overflow}, 32'd1);
    check("ovf.level",    {27'd0, bus.level},    32'd16);
    bus.ovf_clr = 1'b1; tick(1); bus.ovf_clr = 1'b0;

    // Full plus event plus pop in the same cycle.
    v = v + 32'd40;
    bus.count_latched = v; bus.rd_en = 1'b1; tick(1); bus.rd_en = 1'b0;
    check("fpp.level",    {27'd0, bus.level},    32'd16);
    check("fpp.overflow", {31'd0, bus.overflow}, 32'd0);
    check("fpp.head",     bus.rd_data,           32'd12);
    bus.rd_en = 1'b1; tick(15);
    check("fpp.last",       bus.rd_data,        32'd40);
    check("fpp.last_level", {27'd0, bus.level}, 32'd1);
    tick(1); bus.rd_en = 1'b0;
    check("fpp.drained", {31'd0, bus.rd_valid}, 32'd0);

    // Pop held while empty; each entry pops the cycle after it appears.
    bus.rd_en = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      v = v + 32'(7 + i);
      bus.count_latched = v; tick(1);
      check("pe.visible", bus.rd_data, 32'(7 + i));
      tick(2);
      check("pe.gone", {31'd0, bus.rd_valid}, 32'd0);
    end
    // Back-to-back events with pop held.
    for (int i = 0; i < 4; i++) begin
      v = v + 32'(3 + i);
      bus.count_latched = v; tick(1);
    end
    tick(2);
    bus.rd_en = 1'b0;
    check("b2b.empty", {31'd0, bus.rd_valid}, 32'd0);

    // Asynchronous reset with 5 entries queued.
    for (int i = 0; i < 5; i++) begin
      v = v + 32'd100;
      bus.count_latched = v; tick(1);
    end
    tick(2);
    check("ar.level_before", {27'd0, bus.level}, 32'd5);
    @(posedge clk); #3;
    rstn = 1'b0;
    bus.count_latched = 32'd0;
    #1;
    check("ar.level",       {27'd0, bus.level},    32'd0);
    check("ar.rd_valid",    {31'd0, bus.rd_valid}, 32'd0);
    check("ar.rd_data",     bus.rd_data,           32'd0);
    check("ar.overflow",    {31'd0, bus.overflow}, 32'd0);
    check("ar.event_count", bus.event_count,       32'd0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    bus.count_latched = 32'd77; tick(3);
    check("ar.prime_level", {27'd0, bus.level}, 32'd0);
    check("ar.prime_count", bus.event_count,    32'd1);
    bus.count_latched = 32'd90; tick(1);
    check("ar.first_interval", bus.rd_data, 32'd13);
    tick(2);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
